// File: rtl/gps_feed_sample_rx.sv
// gps_feed_sample_rx: receive side of the recorded-sample feed.
// Captures toggle-flagged PIO writes from the feed processor, buffers the
// 3-bit samples in a small FIFO and replays them to the correlator at a
// fixed pace of one sample every SAMPLE_DIV clocks.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | replay stopped; writes are still buffered
// S_PRIME | stream active, waiting for the FIFO to reach PRIME_LEVEL
// S_RUN   | paced replay; an empty FIFO at a tick flags underrun
// S_DRAIN | stream ended; replay continues until the FIFO runs dry
module gps_feed_sample_rx #(
  parameter int ADDR_W       = 4,
  parameter int SAMPLE_DIV   = 4,
  parameter int PRIME_LEVEL  = 8,
  parameter int READY_MARGIN = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [7:0]        feed_port_i,
  input  logic              enable_i,
  input  logic              clear_flags_i,
  output logic              feed_ready_o,
  output logic              sample_valid_o,
  output logic              sample_sign_o,
  output logic [1:0]        sample_mag_o,
  output logic [ADDR_W:0]   fifo_level_o,
  output logic              running_o,
  output logic              underrun_o,
  output logic              overflow_o
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PRIME_L   = (ADDR_W + 1)'(PRIME_LEVEL);
  localparam logic [ADDR_W:0] MARGIN_L  = (ADDR_W + 1)'(READY_MARGIN);
  localparam logic [ADDR_W:0] LVL_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [7:0]      PACE_LAST = 8'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e              state_q, state_d;

  logic [7:0]          feed_q;
  logic                prev_toggle_q;

  logic [7:0]          pace_q, pace_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic [2:0]          mem_q [DEPTH];
  logic [2:0]          rd_data;

  logic                sample_valid_q, sample_valid_d;
  logic                sample_sign_q, sample_sign_d;
  logic [1:0]          sample_mag_q, sample_mag_d;
  logic                feed_ready_q, feed_ready_d;
  logic                underrun_q, underrun_d;
  logic                overflow_q, overflow_d;

  logic                write_det;
  logic                fifo_empty;
  logic                fifo_full;
  logic                active_st;
  logic                tick;
  logic                pop;
  logic                push;
  logic                overflow_set;
  logic                underrun_set;

  // Register the feed port once and keep the previous toggle bit for edge detection.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      feed_q        <= '0;
      prev_toggle_q <= 1'b0;
    end else begin
      feed_q        <= feed_port_i;
      prev_toggle_q <= feed_q[6];
    end
  end

  // A toggle flip marks a fresh write; a pop in the same cycle frees room for it.
  assign write_det    = feed_q[6] ^ prev_toggle_q;
  assign fifo_empty   = (level_q == '0);
  assign fifo_full    = (level_q == DEPTH_L);
  assign active_st    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign tick         = active_st && (pace_q == PACE_LAST);
  assign pop          = tick && !fifo_empty;
  assign push         = write_det && (!fifo_full || pop);
  assign overflow_set = write_det && fifo_full && !pop;
  assign underrun_set = (state_q == S_RUN) && tick && fifo_empty;
  assign rd_data      = mem_q[rd_ptr_q];

  // Pacing counter runs only while replaying, so the first tick lands SAMPLE_DIV clocks in.
  always_comb begin
    pace_d = '0;
    if (active_st) begin
      pace_d = tick ? '0 : pace_q + 8'd1;
    end
  end

  // FIFO pointer and occupancy update; simultaneous push and pop leave the level alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Sample presentation: strobe for one cycle on a pop, otherwise hold the last sample.
  always_comb begin
    sample_valid_d = pop;
    sample_sign_d  = sample_sign_q;
    sample_mag_d   = sample_mag_q;
    if (pop) begin
      sample_sign_d = rd_data[2];
      sample_mag_d  = rd_data[1:0];
    end
  end

  // Flow control and sticky flags; a set event beats a clear in the same cycle.
  always_comb begin
    feed_ready_d = ((DEPTH_L - level_q) >= MARGIN_L);
    underrun_d   = underrun_q;
    overflow_d   = overflow_q;
    if (clear_flags_i) begin
      underrun_d = 1'b0;
      overflow_d = 1'b0;
    end
    if (underrun_set) begin
      underrun_d = 1'b1;
    end
    if (overflow_set) begin
      overflow_d = 1'b1;
    end
  end

  // Replay FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable_i && feed_q[7]) begin
          state_d = S_PRIME;
        end
      end
      S_PRIME: begin
        if (!enable_i || !feed_q[7]) begin
          state_d = S_IDLE;
        end else if (level_q >= PRIME_L) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (tick && fifo_empty) begin
          state_d = S_PRIME;
        end else if (!feed_q[7]) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (tick && fifo_empty) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: pacing, FIFO bookkeeping, presented sample and flags.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pace_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      sample_valid_q <= 1'b0;
      sample_sign_q  <= 1'b0;
      sample_mag_q   <= '0;
      feed_ready_q   <= 1'b1;
      underrun_q     <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      pace_q         <= pace_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      sample_valid_q <= sample_valid_d;
      sample_sign_q  <= sample_sign_d;
      sample_mag_q   <= sample_mag_d;
      feed_ready_q   <= feed_ready_d;
      underrun_q     <= underrun_d;
      overflow_q     <= overflow_d;
    end
  end

  // Sample storage; contents need no reset since occupancy is tracked by level_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= feed_q[2:0];
    end
  end

  assign feed_ready_o   = feed_ready_q;
  assign sample_valid_o = sample_valid_q;
  assign sample_sign_o  = sample_sign_q;
  assign sample_mag_o   = sample_mag_q;
  assign fifo_level_o   = level_q;
  assign running_o      = active_st;
  assign underrun_o     = underrun_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_gps_feed_sample_rx.sv
// Directed bench for gps_feed_sample_rx with hand-computed expectations.
module tb_gps_feed_sample_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] feed_port;
  logic       enable;
  logic       clear_flags;
  logic       feed_ready;
  logic       sample_valid;
  logic       sample_sign;
  logic [1:0] sample_mag;
  logic [4:0] fifo_level;
  logic       running;
  logic       underrun;
  logic       overflow;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic       act = 1'b0;
  logic       tog = 1'b0;
  logic [2:0] dat = 3'd0;

  int         stb_cyc[$];
  logic [2:0] stb_dat[$];
  int         run_rise = -1;
  int         run_fall = -1;
  int         ur_rise  = -1;
  logic       run_prev = 1'b0;
  logic       ur_prev  = 1'b0;

  gps_feed_sample_rx #(
    .ADDR_W      (4),
    .SAMPLE_DIV  (4),
    .PRIME_LEVEL (8),
    .READY_MARGIN(4)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .feed_port_i   (feed_port),
    .enable_i      (enable),
    .clear_flags_i (clear_flags),
    .feed_ready_o  (feed_ready),
    .sample_valid_o(sample_valid),
    .sample_sign_o (sample_sign),
    .sample_mag_o  (sample_mag),
    .fifo_level_o  (fifo_level),
    .running_o     (running),
    .underrun_o    (underrun),
    .overflow_o    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record strobes and state edges on the falling clock edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sample_valid) begin
        stb_cyc.push_back(cyc);
        stb_dat.push_back({sample_sign, sample_mag});
      end
      if (running && !run_prev) run_rise = cyc;
      if (!running && run_prev) run_fall = cyc;
      if (underrun && !ur_prev) ur_rise = cyc;
      run_prev = running;
      ur_prev  = underrun;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive();
    feed_port = {act, tog, 3'b000, dat};
  endtask

  task automatic wr(input logic [2:0] d);
    tog = ~tog;
    dat = d;
    drive();
  endtask

  task automatic clr_mon();
    stb_cyc.delete();
    stb_dat.delete();
    run_rise = -1;
    run_fall = -1;
    ur_rise  = -1;
    run_prev = running;
    ur_prev  = underrun;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    act         = 1'b0;
    tog         = 1'b0;
    dat         = 3'd0;
    drive();
    enable      = 1'b0;
    clear_flags = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    clr_mon();
  endtask

  function automatic int qc(input int i);
    return (i < stb_cyc.size()) ? stb_cyc[i] : -1;
  endfunction

  function automatic int qd(input int i);
    return (i < stb_dat.size()) ? int'(stb_dat[i]) : -1;
  endfunction

  task automatic check_pacing(input string tag);
    int errs = 0;
    for (int i = 1; i < stb_cyc.size(); i++)
      if (stb_cyc[i] - stb_cyc[i-1] != 4) errs++;
    check(tag, errs, 0);
  endtask

  initial begin
    int d8, drop_cyc, errs, seen, after;

    // Reset values
    reset_n = 1'b0; feed_port = 8'h00; enable = 1'b0; clear_flags = 1'b0;
    step(2);
    check("rst_outs", int'({sample_valid, sample_sign, sample_mag, running,
                            underrun, overflow, feed_ready}), 1);
    check("rst_level", int'(fifo_level), 0);

    // 1 + 3: prime with 8 spaced writes, paced replay, then underrun
    do_reset();
    enable = 1'b1; act = 1'b1; drive();
    step(2);
    d8 = 0;
    for (int k = 0; k < 8; k++) begin
      wr(3'(k));
      d8 = cyc;
      step(3);
    end
    step(50);
    check("t1_run_entry", run_rise, d8 + 3);
    check("t1_first_strobe", qc(0), d8 + 7);
    check("t1_n_strobes", stb_cyc.size(), 8);
    check_pacing("t1_pacing");
    errs = 0;
    for (int i = 0; i < 8; i++) if (qd(i) != i) errs++;
    check("t1_order", errs, 0);
    check("t3_last_strobe", qc(7), d8 + 35);
    check("t3_underrun_cycle", ur_rise, d8 + 39);
    check("t3_run_fall", run_fall, d8 + 39);
    check("t3_underrun", int'(underrun), 1);
    check("t3_running", int'(running), 0);

    // 2: overflow saturation, lagged feed_ready, flag clear
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wr(3'(i));
      step(1);
      if (i == 12) check("t2_lvl12", int'(fifo_level), 12);
      if (i == 13) begin
        check("t2_lvl13", int'(fifo_level), 13);
        check("t2_ready_lag", int'(feed_ready), 1);
      end
      if (i == 14) check("t2_ready_low", int'(feed_ready), 0);
      if (i == 16) begin
        check("t2_lvl16", int'(fifo_level), 16);
        check("t2_ovf_not_yet", int'(overflow), 0);
      end
      if (i == 17) check("t2_ovf_set", int'(overflow), 1);
    end
    step(3);
    check("t2_lvl_sat", int'(fifo_level), 16);
    check("t2_ready_full", int'(feed_ready), 0);
    clear_flags = 1'b1;
    step(1);
    clear_flags = 1'b0;
    check("t2_clear", int'(overflow), 0);
    wr(3'd0);
    step(1);
    clear_flags = 1'b1;
    step(1);
    clear_flags = 1'b0;
    check("t2_set_wins", int'(overflow), 1);

    // 4: drop stream with 5 queued -> DRAIN
    do_reset();
    enable = 1'b1; act = 1'b1; drive();
    step(2);
    for (int k = 0; k < 8; k++) begin
      wr(3'(7 - k));
      step(1);
    end
    seen = 0;
    for (int c = 0; c < 60 && seen < 3; c++) begin
      step(1);
      if (sample_valid) seen++;
    end
    check("t4_three_strobes", seen, 3);
    act = 1'b0; drive();
    drop_cyc = cyc;
    step(40);
    after = 0;
    foreach (stb_cyc[i]) if (stb_cyc[i] > drop_cyc) after++;
    check("t4_drain_strobes", after, 5);
    check("t4_n_strobes", stb_cyc.size(), 8);
    check_pacing("t4_pacing");
    errs = 0;
    for (int i = 0; i < 8; i++) if (qd(i) != 7 - i) errs++;
    check("t4_order", errs, 0);
    check("t4_last_strobe", qc(7), drop_cyc + 20);
    check("t4_idle_cycle", run_fall, drop_cyc + 24);
    check("t4_underrun", int'(underrun), 0);
    check("t4_level", int'(fifo_level), 0);

    // 5: push on a full FIFO in the same cycle as a pop
    do_reset();
    act = 1'b1; drive();
    step(1);
    for (int k = 0; k < 16; k++) begin
      wr(3'(k));
      step(1);
    end
    step(3);
    check("t5_full", int'(fifo_level), 16);
    enable = 1'b1;
    for (int c = 0; c < 20 && !running; c++) step(1);
    check("t5_run", int'(running), 1);
    step(2);
    wr(3'b101);
    step(1);
    check("t5_lvl_pre", int'(fifo_level), 16);
    step(1);
    check("t5_tick", int'(sample_valid), 1);
    check("t5_lvl_tick", int'(fifo_level), 16);
    check("t5_ovf", int'(overflow), 0);
    step(80);
    check("t5_n_strobes", stb_cyc.size(), 17);
    check_pacing("t5_pacing");
    errs = 0;
    for (int i = 0; i < 16; i++) if (qd(i) != (i % 8)) errs++;
    if (qd(16) != 5) errs++;
    check("t5_order", errs, 0);

    // 6: asynchronous reset mid-RUN
    do_reset();
    enable = 1'b1; act = 1'b1; drive();
    step(2);
    for (int k = 0; k < 8; k++) begin
      wr(3'(k));
      step(1);
    end
    for (int c = 0; c < 40 && !sample_valid; c++) step(1);
    check("t6_strobe", int'(sample_valid), 1);
    step(1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_outs", int'({sample_valid, sample_sign, sample_mag, running,
                               underrun, overflow, feed_ready}), 1);
    check("t6_rst_level", int'(fifo_level), 0);
    #2;
    reset_n = 1'b1;
    step(1);
    clr_mon();
    step(30);
    check("t6_no_strobe", stb_cyc.size(), 0);
    check("t6_level", int'(fifo_level), 0);
    check("t6_running", int'(running), 0);
    for (int k = 0; k < 8; k++) begin
      wr(3'(k));
      step(1);
    end
    step(19);
    check("t6_reprime_strobes", stb_cyc.size(), 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gps_feed_sample_rx.md
Name: gps_feed_sample_rx

Overview:
- Receiving end of the data-feed path. The feed processor writes recorded GPS front-end samples, one per PIO write, to an 8-bit output port.
- This block detects each new write on that port and buffers the sample in a FIFO.
- It replays samples to the correlator at a fixed, front-end-like rate: one sample every SAMPLE_DIV clocks.
- It returns flow-control status (feed_ready) that the processor polls before each write.
- It sits on the same clk as the feed processor, between the feed port and the tracking channels.

Parameters:
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W = 16 entries.
- SAMPLE_DIV, 4, clocks between output samples. Legal values are 2..255.
- PRIME_LEVEL, 8, FIFO level required before output starts. Must be <= depth.
- READY_MARGIN, 4, feed_ready is deasserted when free entries < READY_MARGIN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- feed_port  in  8  feed processor PIO byte.
  - [7] stream_active
  - [6] write toggle
  - [5:3] reserved, ignored
  - [2] sign
  - [1:0] magnitude
- enable  in  1  replay enable.
- clear_flags  in  1  synchronous clear of the sticky flags.
- feed_ready  out  1  FIFO has at least READY_MARGIN free entries.
- sample_valid  out  1  one-cycle strobe; a new sample is presented.
- sample_sign  out  1  sample sign; held between strobes.
- sample_mag  out  2  sample magnitude; held between strobes.
- fifo_level  out  ADDR_W+1  current FIFO occupancy, 0..depth.
- running  out  1  high while in the RUN or DRAIN state.
- underrun  out  1  sticky flag.
- overflow  out  1  sticky flag.

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs are 0 except feed_ready=1. FIFO is empty, FSM is in IDLE, the pacing counter is 0, and the toggle history register is 0.
- Input capture:
  - feed_port is registered once into feed_q every cycle.
  - A write is detected when feed_q[6] differs from prev_toggle. prev_toggle updates every cycle.
  - A detected write pushes feed_q[2:0] into the FIFO on that same edge.
  - Latency: port change visible at edge N is pushed at edge N+1; fifo_level reflects it after edge N+1.
  - A write is pushed in any FSM state, including IDLE.
- Push when full (level = depth): the data is dropped, the level is unchanged, and overflow sets.
- Pop: occurs only on a pacing tick in RUN or DRAIN with a non-empty FIFO. The popped data loads sample_sign/sample_mag, and sample_valid=1 for that one cycle.
- Simultaneous push and pop: both take effect and the level is unchanged. A push to a full FIFO in the same cycle as a pop is accepted, not dropped.
- Pacing counter: counts 0..SAMPLE_DIV-1 and wraps. A tick occurs when the count equals SAMPLE_DIV-1. The counter resets to 0 whenever the FSM is not in RUN or DRAIN, so the first tick comes SAMPLE_DIV cycles after entering RUN.
- FSM:
  - IDLE -> PRIME when enable=1 and feed_q[7]=1.
  - PRIME -> RUN when fifo_level >= PRIME_LEVEL.
  - PRIME -> IDLE when enable=0 or feed_q[7]=0.
  - RUN: on a tick with an empty FIFO, underrun sets, no strobe is issued, and the FSM goes to PRIME.
  - RUN -> DRAIN when feed_q[7]=0.
  - RUN -> IDLE when enable=0 (FIFO contents retained).
  - DRAIN: continues paced pops. -> IDLE when the FIFO is empty at a tick; no underrun is flagged in DRAIN. -> IDLE immediately when enable=0.
- feed_ready = (depth - fifo_level) >= READY_MARGIN. This is registered, so it lags the level by 1 cycle.
- Sticky flags: underrun and overflow hold until clear_flags=1 or reset. If clear_flags and a set event occur in the same cycle, set wins.
- Reset asserted mid-stream: immediate return to reset values. No partial sample is emitted.
- fifo_level arithmetic is unsigned ADDR_W+1 bits and never wraps. Read and write pointers are ADDR_W bits and wrap modulo depth.

Test Plan:
1. Reset, enable=1, feed_port bit7=1, toggle 8 writes with samples 0..7 (one write every 3 clocks), SAMPLE_DIV=4.
   - Required: PRIME->RUN after the 8th push.
   - Required: sample_valid strobes exactly every 4 clocks, first strobe 4 clocks after RUN entry.
   - Required: output order 0..7 (sign,mag); underrun=0.
2. With enable=0, write 20 toggles back-to-back.
   - Required: fifo_level saturates at 16 and overflow=1.
   - Required: feed_ready=0 once level >= 13.
   - Required: pulse clear_flags -> overflow=0.
3. Enter RUN with 8 samples and stop writing.
   - Required: after the 8th strobe, the next tick sets underrun, running=0, state returns to PRIME, no extra strobe.
4. In RUN with 5 samples queued, drop bit7.
   - Required: DRAIN emits exactly 5 paced strobes, then IDLE; underrun stays 0.
5. At level=16 in RUN, apply a toggle on the same cycle as a pacing tick.
   - Required: level stays 16, overflow stays 0, the new sample appears in order.
6. Assert reset_n=0 mid-RUN between ticks.
   - Required: all outputs immediately 0 (feed_ready=1), level=0, no strobe after release until re-primed.
